uart_tx_scheduler: RTL
======================

// Module: uart_tx_scheduler
// PURPOSE
//  Shares one UART transmitter (8N1, byte-wide start/done handshake) among NREQ byte-stream requesters.
//  Round-robin arbitration with packet locking: once granted, a requester keeps the link until it sends
//  a byte flagged last, or until MAX_BURST bytes have gone out. Sits between the client streams and the TX core.
//  A watchdog recovers from a missing done pulse.
// PARAMETERS
//  NREQ         4       number of requesters (2..8)
//  MAX_BURST    16      max bytes per grant before forced release (1..255)
//  TIMEOUT_CYC  200000  clk cycles allowed in WAIT_DONE, or in locked-idle, before error recovery
// PORTS
//  clk          in   1          system clock, rising edge
//  reset        in   1          asynchronous, active-high
//  req_valid    in   NREQ       per-requester byte available
//  req_data     in   8*NREQ     byte of requester i in [8*i+7:8*i]
//  req_last     in   NREQ       byte is final of its packet
//  req_ready    out  NREQ       one-hot accept; transfer when valid&ready on a clk edge
//  tx_start     out  1          one-cycle start pulse to TX core
//  tx_data      out  8          byte to TX core, held stable from start until done
//  tx_done      in   1          one-cycle completion pulse from TX core
//  busy         out  1          high outside IDLE, or while a lock is held
//  grant_id     out  clog2(NREQ) current/last granted requester
//  err_timeout  out  1          sticky watchdog flag
//  err_clr      in   1          synchronous clear of err_timeout
// BEHAVIOUR
//  Reset values
//   - Outputs: req_ready=0, tx_start=0, tx_data=0, busy=0, grant_id=0, err_timeout=0.
//   - Internal: state=IDLE, rr pointer=0, lock=0, burst count=0, watchdog=0.
//  IDLE: if unlocked, the winner is the first req_valid at or after the rr pointer, wrapping modulo NREQ.
//   - If locked, only the locked requester is eligible.
//   - req_ready[winner] asserts combinationally in IDLE.
//   - On the transfer edge: capture tx_data, grant_id; set lock; increment burst count; go to START.
//   - Accept latency: 0 cycles from valid in IDLE.
//  START: tx_start=1 for exactly this one cycle; go to WAIT_DONE. Watchdog cleared.
//  WAIT_DONE: watchdog increments each cycle.
//   - tx_done=1 -> if last or burst==MAX_BURST: clear lock, burst=0, ptr=grant_id+1 (wraps). Go to IDLE.
//   - Otherwise go to IDLE with the lock kept.
//   - watchdog==TIMEOUT_CYC-1 with no done -> RECOVER.
//  RECOVER: one cycle; set err_timeout; clear lock, burst=0, ptr=grant_id+1; go to IDLE.
//  Locked stall: in IDLE while locked and the locked requester is not valid, the watchdog counts.
//   - On reaching TIMEOUT_CYC-1: set err_timeout, drop lock, advance ptr. Other requesters are never starved forever.
//  Boundary rules
//   - tx_done outside WAIT_DONE is ignored.
//   - tx_done on the same edge as watchdog expiry: done wins, no error.
//   - Simultaneous requests: strict rotation; after a release the releaser has lowest priority.
//   - Byte counts toward the burst even if last; burst==MAX_BURST with last=0 forces release (no error).
//   - err_clr and a new timeout on the same edge: set wins.
//   - req_ready is never asserted outside IDLE.
//   - At most one req_ready bit is high.
//   - reset mid-transfer: immediate return to reset values. The TX core is reset by the same signal.
//  Widths: burst counter 8 bits; watchdog clog2(TIMEOUT_CYC) bits.
//   - ptr arithmetic is modulo NREQ, with explicit wrap (not power-of-2 truncation).
// STRUCTURE
//  uart_pkg: state encodings IDLE=0, START=1, WAIT_DONE=2, RECOVER=3; byte width constant 8.
//  Sub-module rr_arbiter (NREQ): inputs req vector, pointer, lock_en, lock_id; outputs one-hot grant, grant index, any.
//   - Purely combinational.
//  Top: FSM, data/grant registers, burst counter, watchdog, error flag.
// TESTING
//  T1 single requester: req1 sends 0xA5 last=1.
//   - Expect req_ready[1] in IDLE, tx_start 1 cycle later, tx_data=0xA5 held.
//   - After done: lock clear, ptr=2.
//  T2 contention: all four valid continuously, single-byte packets.
//   - Grant order 0,1,2,3,0; exactly one tx_start per tx_done.
//  T3 packet lock: req2 sends 3 bytes (last on 3rd) while req0 is valid.
//   - Expect 3 consecutive req2 grants, then req3 if valid, else req0.
//  T4 burst cap: MAX_BURST=4; req1 streams 6 bytes, last=0.
//   - Expect a forced release after byte 4; req0 is served next.
//   - req1 resumes on its next turn; err_timeout stays 0.
//  T5 watchdog: TIMEOUT_CYC=50; tx_done withheld.
//   - err_timeout set 50 cycles after start; FSM in IDLE, lock clear.
//   - err_clr clears it; next request is served normally.
//  T6 reset: assert reset during WAIT_DONE.
//   - All outputs 0 the same cycle; a stale tx_done after release is ignored.

Source files
------------

// File: rtl/uart_tx_scheduler_pkg.sv
// uart_tx_scheduler_pkg: shared FSM encoding, byte width and modulo helper
package uart_tx_scheduler_pkg;
  localparam int BYTE_W = 8;
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_DONE = 2'd2,
    RECOVER   = 2'd3
  } state_t;
  function automatic int wrap_inc(input int v, input int n);
    return (v == n - 1) ? 0 : v + 1;
  endfunction
endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// uart_tx_scheduler_rr_arbiter: round-robin pick starting at ptr, or only the locked requester
module uart_tx_scheduler_rr_arbiter #(
  parameter int NREQ = 4,
  localparam int IW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  input  logic            lock_en,
  input  logic [IW-1:0]   lock_id,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   gidx,
  output logic            any
);
  // scan from the farthest offset back to ptr so the nearest valid requester overwrites the rest
  always_comb begin
    gidx = '0;
    any = 1'b0;
    if (lock_en) begin
      gidx = lock_id;
      any = req[lock_id];
    end else begin
      for (int i = NREQ - 1; i >= 0; i--) begin
        if (req[IW'((int'(ptr) + i) % NREQ)]) begin
          gidx = IW'((int'(ptr) + i) % NREQ);
          any = 1'b1;
        end
      end
    end
    grant = any ? NREQ'(1) << gidx : '0;
  end
endmodule

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin, packet-locked sharing of one UART TX core with a done watchdog
module uart_tx_scheduler
  import uart_tx_scheduler_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int MAX_BURST = 16,
  parameter int TIMEOUT_CYC = 200000,
  localparam int IW = $clog2(NREQ),
  localparam int WW = $clog2(TIMEOUT_CYC)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [BYTE_W*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]        req_last,
  output logic [NREQ-1:0]        req_ready,
  output logic                   tx_start,
  output logic [BYTE_W-1:0]      tx_data,
  input  logic                   tx_done,
  output logic                   busy,
  output logic [IW-1:0]          grant_id,
  output logic                   err_timeout,
  input  logic                   err_clr
);
  state_t state;
  logic [IW-1:0] ptr;
  logic lock;
  logic last_q;
  logic [7:0] burst;
  logic [WW-1:0] wdog;
  logic [NREQ-1:0] grant;
  logic [IW-1:0] gidx;
  logic any;
  logic [IW-1:0] ptr_next;
  logic wd_end;
  uart_tx_scheduler_rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req(req_valid),
    .ptr(ptr),
    .lock_en(lock),
    .lock_id(grant_id),
    .grant(grant),
    .gidx(gidx),
    .any(any)
  );
  assign req_ready = (state == IDLE) ? grant : '0;
  assign busy = (state != IDLE) || lock;
  assign ptr_next = IW'(wrap_inc(int'(grant_id), NREQ));
  assign wd_end = wdog == WW'(TIMEOUT_CYC - 1);
  // sequencer: accept in IDLE, pulse start, await done under watchdog, release on last/cap/timeout
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      ptr <= '0;
      lock <= 1'b0;
      last_q <= 1'b0;
      burst <= '0;
      wdog <= '0;
      tx_start <= 1'b0;
      tx_data <= '0;
      grant_id <= '0;
      err_timeout <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      if (err_clr) err_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (any) begin
            tx_data <= req_data[gidx*BYTE_W +: BYTE_W];
            grant_id <= gidx;
            last_q <= req_last[gidx];
            lock <= 1'b1;
            burst <= burst + 8'd1;
            wdog <= '0;
            tx_start <= 1'b1;
            state <= START;
          end else if (lock) begin
            if (wd_end) begin
              err_timeout <= 1'b1;
              lock <= 1'b0;
              burst <= '0;
              ptr <= ptr_next;
              wdog <= '0;
            end else begin
              wdog <= wdog + WW'(1);
            end
          end else begin
            wdog <= '0;
          end
        end
        START: begin
          wdog <= '0;
          state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (tx_done) begin
            if (last_q || burst == 8'(MAX_BURST)) begin
              lock <= 1'b0;
              burst <= '0;
              ptr <= ptr_next;
            end
            wdog <= '0;
            state <= IDLE;
          end else if (wd_end) begin
            state <= RECOVER;
          end else begin
            wdog <= wdog + WW'(1);
          end
        end
        default: begin
          err_timeout <= 1'b1;
          lock <= 1'b0;
          burst <= '0;
          ptr <= ptr_next;
          wdog <= '0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule
